// File: rtl/store_pkg.sv
// store_pkg: shared opcodes, FSM state encoding and the legality helper for
// the MEM-stage store path.
package store_pkg;

  localparam logic [5:0] OP_LW = 6'd16;
  localparam logic [5:0] OP_LH = 6'd18;
  localparam logic [5:0] OP_LB = 6'd20;
  localparam logic [5:0] OP_SW = 6'd24;
  localparam logic [5:0] OP_SH = 6'd26;
  localparam logic [5:0] OP_SB = 6'd28;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    FAULT = 3'd4
  } state_e;

  // A store is legal only if its opcode is a store and the address is
  // naturally aligned for that width.
  function automatic logic store_legal(input logic [5:0] op, input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_SW:   ok = (lane == 2'b00);
      OP_SH:   ok = (lane[0] == 1'b0);
      OP_SB:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_merge.sv
// store_merge: combinational lane placement for stores into a word memory
// without byte enables.
//   old_i    : word currently held in memory
//   wdata_i  : store operand (sh uses [15:0], sb uses [7:0])
//   op_i     : store opcode
//   lane_i   : byte address bits [1:0]
//   merged_o : word to write back
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [5:0]  op_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (op_i)
      OP_SW: merged_o = wdata_i;
      OP_SH: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      OP_SB: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// store_unit: MEM-stage data-memory write path. Full words are written
// directly; halfwords and bytes go through read-modify-write.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   op, addr, wdata     : store request
//   dm_addr, dm_re, dm_rdata, dm_we, dm_wdata : word-wide memory port
//   done, err           : one-cycle completion / fault pulses
//
// state | meaning
// IDLE  | ready for a request
// READ  | dm_re asserted for the target word
// MERGE | read data arrives, lanes replaced into dm_wdata_q
// WRITE | dm_we asserted, done pulse
// FAULT | misaligned or illegal op, done+err pulse, no memory access
module store_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  input  logic [31:0]       dm_rdata,
  output logic              dm_we,
  output logic [31:0]       dm_wdata,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [5:0]        op_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [31:0]       merge_q;
  logic              req_ready_q, dm_re_q, dm_we_q, done_q, err_q;
  logic [31:0]       merged;

  store_merge u_merge (
    .old_i    (dm_rdata),
    .wdata_i  (wdata_q),
    .op_i     (op_q),
    .lane_i   (lane_q),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!store_legal(op, addr[1:0])) state_d = FAULT;
          else if (op == OP_SW)            state_d = WRITE;
          else                             state_d = READ;
        end
      end
      READ:    state_d = MERGE;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe and never depend combinationally on the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      dm_addr_q   <= '0;
      merge_q     <= '0;
      req_ready_q <= 1'b1;
      dm_re_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      dm_re_q     <= (state_d == READ);
      dm_we_q     <= (state_d == WRITE);
      done_q      <= (state_d == WRITE) || (state_d == FAULT);
      err_q       <= (state_d == FAULT);
      if (state_q == IDLE && req_valid) begin
        op_q    <= op;
        lane_q  <= addr[1:0];
        wdata_q <= wdata;
        if (state_d != FAULT) dm_addr_q <= {addr[ADDR_W-1:2], 2'b00};
        // Full words bypass the merge; load them straight into the write register.
        if (state_d == WRITE) merge_q <= wdata;
      end
      if (state_q == MERGE) merge_q <= merged;
    end
  end

  assign req_ready = req_ready_q;
  assign dm_re     = dm_re_q;
  assign dm_we     = dm_we_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = merge_q;

endmodule
